vending_machine_param: RTL and testbench

- Parametrised successor to the fixed three-item vending controller.
- Configurable item count and price table; credit accumulator of configurable width; multi-denomination coin acceptance with rejection.
- Sequential greedy change dispensing over a valid/ready handshake to the coin hopper; explicit cancel/refund.
- Sits between the coin acceptor / keypad front end and the item-release and hopper drivers.

---
 rtl/vending_machine_param.sv | 256 +++++++++++++++++++++++++
 tb/tb_vending_machine_param.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_param.sv
// Parametrised vending controller: priced item table, bounded credit, coin rejection and
// greedy change dispensing over a valid/ready hopper handshake. Optional macro: VM_TIMEOUT_EN.
module vending_machine_param #(
    parameter int                            NUM_ITEMS   = 4,
    parameter int                            ITEM_W      = 6,
    parameter int                            CREDIT_W    = 8,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_TABLE = {8'd25, 8'd15, 8'd10, 8'd5},
    parameter int                            MAX_CREDIT  = 100,
    parameter int                            TIMEOUT_CYC = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [4:0]          coin_val,
    input  logic                sel_valid,
    input  logic [ITEM_W-1:0]   sel_item,
    input  logic                cancel,
    input  logic                change_ready,
    output logic [ITEM_W-1:0]   item_out,
    output logic                vend_valid,
    output logic                coin_reject,
    output logic [4:0]          reject_val,
    output logic                sel_err,
    output logic                change_valid,
    output logic [4:0]          change_coin,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_e;

    localparam logic [CREDIT_W:0]   MAX_CREDIT_W = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [ITEM_W:0]     NUM_ITEMS_W  = (ITEM_W+1)'(NUM_ITEMS);
    localparam logic [CREDIT_W-1:0] CR_ZERO      = {CREDIT_W{1'b0}};

    function automatic logic coin_legal(input logic [4:0] v);
        logic ok;
        case (v)
            5'd1, 5'd5, 5'd10, 5'd20: ok = 1'b1;
            default:                  ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Out-of-range indices resolve to price 0 so they fall into the "not stocked" reject path.
    function automatic logic [CREDIT_W-1:0] price_of(input logic [ITEM_W-1:0] idx);
        logic [CREDIT_W-1:0] p;
        p = CR_ZERO;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if ({1'b0, idx} == (ITEM_W+1)'(i)) begin
                p = PRICE_TABLE[i*CREDIT_W +: CREDIT_W];
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

    function automatic logic [4:0] greedy_coin(input logic [CREDIT_W-1:0] c);
        logic [4:0] g;
        if (c >= CREDIT_W'(5'd20)) begin
            g = 5'd20;
        end else if (c >= CREDIT_W'(5'd10)) begin
            g = 5'd10;
        end else if (c >= CREDIT_W'(5'd5)) begin
            g = 5'd5;
        end else if (c >= CREDIT_W'(5'd1)) begin
            g = 5'd1;
        end else begin
            g = 5'd0;
        end
        return g;
    endfunction

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [ITEM_W-1:0]   item_out_q, item_out_d;
    logic                vend_valid_q, vend_valid_d;
    logic                coin_reject_q, coin_reject_d;
    logic [4:0]          reject_val_q, reject_val_d;
    logic                sel_err_q, sel_err_d;
    logic                change_valid_q, change_valid_d;
    logic [4:0]          change_coin_q, change_coin_d;
    logic                busy_q, busy_d;

    logic                at_rest_s;
    logic [CREDIT_W:0]   coin_sum_s;
    logic [CREDIT_W-1:0] sel_price_s;
    logic                sel_ok_s;
    logic                coin_rej_s;
    logic                coin_acc_s;
    logic                strobe_s;
    logic                tmo_hit_s;

    // Input qualification: coin acceptance, selection legality and the widened credit sum.
    always_comb begin
        at_rest_s   = (state_q == ST_IDLE) || (state_q == ST_CREDIT);
        strobe_s    = coin_valid || sel_valid || cancel;
        coin_sum_s  = {1'b0, credit_q} + (CREDIT_W+1)'(coin_val);
        sel_price_s = price_of(sel_item);
        sel_ok_s    = (state_q == ST_CREDIT) && ({1'b0, sel_item} < NUM_ITEMS_W) &&
                      (sel_price_s != CR_ZERO) && (credit_q >= sel_price_s);
        coin_rej_s  = coin_valid && (!at_rest_s || cancel || sel_valid ||
                      !coin_legal(coin_val) || (coin_sum_s > MAX_CREDIT_W));
        coin_acc_s  = coin_valid && !coin_rej_s;
    end

`ifdef VM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Inactivity counter: runs only while credit waits in CREDIT with no strobes.
    always_comb begin
        tmo_hit_s = 1'b0;
        if ((state_q == ST_CREDIT) && !strobe_s) begin
            if (tmo_q == TMO_LAST) begin
                tmo_hit_s = 1'b1;
                tmo_d     = {TMO_W{1'b0}};
            end else begin
                tmo_d     = tmo_q + TMO_W'(1'b1);
            end
        end else begin
            tmo_d = {TMO_W{1'b0}};
        end
    end

    // Inactivity counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_q <= {TMO_W{1'b0}};
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Next-state and registered-output decode; priority is cancel > select > coin.
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        item_out_d     = {ITEM_W{1'b0}};
        vend_valid_d   = 1'b0;
        coin_reject_d  = coin_rej_s;
        reject_val_d   = coin_rej_s ? coin_val : 5'd0;
        sel_err_d      = 1'b0;
        change_valid_d = change_valid_q;
        change_coin_d  = change_coin_q;

        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                if (cancel || tmo_hit_s) begin
                    if ((state_q == ST_CREDIT) && (credit_q != CR_ZERO)) begin
                        state_d        = ST_CHANGE;
                        change_valid_d = 1'b1;
                        change_coin_d  = greedy_coin(credit_q);
                    end else begin
                        state_d = state_q;
                    end
                end else if (sel_valid) begin
                    if (sel_ok_s) begin
                        state_d      = ST_VEND;
                        vend_valid_d = 1'b1;
                        item_out_d   = sel_item;
                        credit_d     = credit_q - sel_price_s;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end else if (coin_acc_s) begin
                    credit_d = coin_sum_s[CREDIT_W-1:0];
                    state_d  = ST_CREDIT;
                end else begin
                    state_d = state_q;
                end
            end
            ST_VEND: begin
                if (credit_q != CR_ZERO) begin
                    state_d        = ST_CHANGE;
                    change_valid_d = 1'b1;
                    change_coin_d  = greedy_coin(credit_q);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHANGE: begin
                // The presented coin is held until the hopper takes it; then the next one is chosen.
                if (change_valid_q && change_ready) begin
                    credit_d = credit_q - CREDIT_W'(change_coin_q);
                    if (credit_d == CR_ZERO) begin
                        state_d        = ST_IDLE;
                        change_valid_d = 1'b0;
                        change_coin_d  = 5'd0;
                    end else begin
                        change_coin_d = greedy_coin(credit_d);
                    end
                end else begin
                    state_d = ST_CHANGE;
                end
            end
            default: begin
                state_d        = ST_IDLE;
                credit_d       = CR_ZERO;
                change_valid_d = 1'b0;
                change_coin_d  = 5'd0;
            end
        endcase

        busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE);
    end

    // State and output registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            credit_q       <= CR_ZERO;
            item_out_q     <= {ITEM_W{1'b0}};
            vend_valid_q   <= 1'b0;
            coin_reject_q  <= 1'b0;
            reject_val_q   <= 5'd0;
            sel_err_q      <= 1'b0;
            change_valid_q <= 1'b0;
            change_coin_q  <= 5'd0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            item_out_q     <= item_out_d;
            vend_valid_q   <= vend_valid_d;
            coin_reject_q  <= coin_reject_d;
            reject_val_q   <= reject_val_d;
            sel_err_q      <= sel_err_d;
            change_valid_q <= change_valid_d;
            change_coin_q  <= change_coin_d;
            busy_q         <= busy_d;
        end
    end

    assign item_out     = item_out_q;
    assign vend_valid   = vend_valid_q;
    assign coin_reject  = coin_reject_q;
    assign reject_val   = reject_val_q;
    assign sel_err      = sel_err_q;
    assign change_valid = change_valid_q;
    assign change_coin  = change_coin_q;
    assign credit       = credit_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed plus randomized bench for vending_machine_param; expectations come from a
// transaction-level model (integer credit, price list, greedy change queue).
module tb_vending_machine_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_valid;
    logic [4:0] coin_val;
    logic       sel_valid;
    logic [5:0] sel_item;
    logic       cancel;
    logic       change_ready;
    logic [5:0] item_out;
    logic       vend_valid;
    logic       coin_reject;
    logic [4:0] reject_val;
    logic       sel_err;
    logic       change_valid;
    logic [4:0] change_coin;
    logic [7:0] credit;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int m_credit = 0;
    int price [4] = '{5, 10, 15, 25};
    int coin_tab [8] = '{1, 5, 10, 20, 20, 10, 7, 2};

    vending_machine_param dut (
        .clk          (clk),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin_val     (coin_val),
        .sel_valid    (sel_valid),
        .sel_item     (sel_item),
        .cancel       (cancel),
        .change_ready (change_ready),
        .item_out     (item_out),
        .vend_valid   (vend_valid),
        .coin_reject  (coin_reject),
        .reject_val   (reject_val),
        .sel_err      (sel_err),
        .change_valid (change_valid),
        .change_coin  (change_coin),
        .credit       (credit),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input int v);
        return (v == 1) || (v == 5) || (v == 10) || (v == 20);
    endfunction

    // mode: 0 random ready, 1 ready always high, 2 ready low for three cycles first.
    task automatic drain(input int mode);
        int q[$];
        int c;
        int rem;
        int n;
        bit rdy;
        c = m_credit;
        rem = m_credit;
        n = 0;
        while (c > 0) begin
            if (c >= 20)      begin q.push_back(20); c -= 20; end
            else if (c >= 10) begin q.push_back(10); c -= 10; end
            else if (c >= 5)  begin q.push_back(5);  c -= 5;  end
            else              begin q.push_back(1);  c -= 1;  end
        end
        while (q.size() > 0 && n < 300) begin
            chk("chg_valid", change_valid, 1);
            chk("chg_coin", change_coin, q[0]);
            chk("chg_credit", credit, rem);
            chk("chg_busy", busy, 1);
            case (mode)
                1:       rdy = 1'b1;
                2:       rdy = (n >= 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            change_ready = rdy;
            step();
            if (rdy) begin
                rem -= q[0];
                void'(q.pop_front());
            end
            n++;
        end
        change_ready = 1'b0;
        chk("drain_done", q.size(), 0);
        chk("chg_end_valid", change_valid, 0);
        chk("chg_end_credit", credit, 0);
        chk("chg_end_busy", busy, 0);
        m_credit = 0;
    endtask

    // One strobe cycle from IDLE/CREDIT; mode 3 leaves any change phase undrained.
    task automatic apply(input bit cv, input int val, input bit sv, input int si,
                         input bit cn, input int mode);
        bit exp_rej, exp_err, exp_vend, exp_chg;
        int pr;
        pr       = (si >= 0 && si < 4) ? price[si] : 0;
        exp_rej  = cv && (cn || sv || !legal(val) || (m_credit + val > 100));
        exp_chg  = cn && (m_credit > 0);
        exp_vend = !cn && sv && (m_credit > 0) && (pr > 0) && (m_credit >= pr);
        exp_err  = !cn && sv && !exp_vend;
        coin_valid = cv; coin_val = val[4:0];
        sel_valid = sv; sel_item = si[5:0]; cancel = cn;
        step();
        coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0;
        if (!cn && !sv && cv && !exp_rej) m_credit += val;
        if (exp_vend) m_credit -= pr;
        chk("coin_reject", coin_reject, exp_rej);
        if (exp_rej) chk("reject_val", reject_val, val);
        chk("sel_err", sel_err, exp_err);
        chk("vend_valid", vend_valid, exp_vend);
        if (exp_vend) chk("item_out", item_out, si);
        chk("credit", credit, m_credit);
        chk("busy", busy, exp_vend || exp_chg);
        chk("change_valid", change_valid, exp_chg);
        if (exp_vend) begin
            coin_valid = 1'b1; coin_val = 5'd5;
            step();
            coin_valid = 1'b0;
            chk("vend_pulse_end", vend_valid, 0);
            chk("busy_coin_reject", coin_reject, 1);
            chk("busy_reject_val", reject_val, 5);
            if (m_credit == 0) begin
                chk("vend_no_change", change_valid, 0);
                chk("vend_idle_busy", busy, 0);
            end else if (mode != 3) begin
                drain(mode);
            end
        end else if (exp_chg && mode != 3) begin
            drain(mode);
        end
    endtask

    initial begin
        int r;
        reset = 1'b0; coin_valid = 1'b0; coin_val = 5'd0; sel_valid = 1'b0;
        sel_item = 6'd0; cancel = 1'b0; change_ready = 1'b0;
        step(); step();
        chk("rst_credit", credit, 0);
        chk("rst_vend", vend_valid, 0);
        chk("rst_chg", change_valid, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;

        // Exact-price vend, no change.
        apply(1, 5, 0, 0, 0, 0);
        apply(1, 10, 0, 0, 0, 0);
        apply(0, 0, 1, 2, 0, 0);
        // Vend with change 10 then 5 back to back.
        apply(1, 20, 0, 0, 0, 0);
        apply(0, 0, 1, 0, 0, 1);
        // Illegal denomination and credit ceiling.
        apply(1, 7, 0, 0, 0, 0);
        apply(1, 20, 0, 0, 0, 0); apply(1, 20, 0, 0, 0, 0); apply(1, 20, 0, 0, 0, 0);
        apply(1, 20, 0, 0, 0, 0); apply(1, 10, 0, 0, 0, 0); apply(1, 5, 0, 0, 0, 0);
        apply(1, 10, 0, 0, 0, 0);
        apply(1, 5, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 1, 0);
        // Unaffordable selection, then cancel with ready held low.
        apply(1, 10, 0, 0, 0, 0);
        apply(0, 0, 1, 3, 0, 0);
        apply(0, 0, 0, 0, 1, 2);
        // Selection in IDLE, invalid index, coin colliding with select and cancel.
        apply(0, 0, 1, 0, 0, 0);
        apply(1, 10, 0, 0, 0, 0);
        apply(0, 0, 1, 5, 0, 0);
        apply(1, 5, 1, 1, 0, 0);
        apply(1, 5, 0, 0, 0, 0);
        apply(1, 5, 0, 0, 1, 1);

        // Reset in the middle of change.
        apply(1, 10, 0, 0, 0, 0);
        apply(1, 5, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 1, 3);
        chk("pre_rst_coin", change_coin, 10);
        reset = 1'b0;
        step();
        reset = 1'b1;
        m_credit = 0;
        chk("mid_rst_credit", credit, 0);
        chk("mid_rst_chg", change_valid, 0);
        chk("mid_rst_coin", change_coin, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_vend", vend_valid, 0);
        chk("mid_rst_item", item_out, 0);
        chk("mid_rst_rej", coin_reject, 0);
        chk("mid_rst_rval", reject_val, 0);
        chk("mid_rst_serr", sel_err, 0);
        apply(1, 5, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 1, 1);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)
                apply(1, coin_tab[$urandom_range(0, 7)], 0, 0, 0, $urandom_range(0, 2));
            else if (r < 8)
                apply(1'($urandom_range(0, 1)), coin_tab[$urandom_range(0, 7)], 1,
                      $urandom_range(0, 5), 0, $urandom_range(0, 2));
            else
                apply(1'($urandom_range(0, 1)), coin_tab[$urandom_range(0, 7)],
                      1'($urandom_range(0, 1)), $urandom_range(0, 5), 1, $urandom_range(0, 2));
        end
        apply(0, 0, 0, 0, 1, 0);

        // Inactivity behaviour.
        apply(1, 5, 0, 0, 0, 0);
`ifdef VM_TIMEOUT_EN
        for (int i = 0; i < 19; i++) begin
            step();
            chk("tmo_wait", change_valid, 0);
        end
        step();
        chk("tmo_fire", change_valid, 1);
        chk("tmo_coin", change_coin, 5);
        drain(1);
`else
        repeat (100) step();
        chk("hold_credit", credit, 5);
        chk("hold_no_chg", change_valid, 0);
        apply(0, 0, 0, 0, 1, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
